// File: rtl/sram_access_arbiter_pkg.sv
// Shared types and defaults for the SRAM access arbiter: FSM states, default
// geometry, and the all-deasserted strobe pattern.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_RD_ACCESS,
    ST_RD_DONE,
    ST_TURN
  } state_t;

  localparam int ADDR_W_DEF   = 20;
  localparam int DATA_W_DEF   = 16;
  localparam int WAIT_CYC_DEF = 2;

  typedef struct packed {
    logic we_n;
    logic ce_n;
    logic oe_n;
    logic lb_n;
    logic ub_n;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '1;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester-side handshake bundle: recorder write channel, DSP read channel
// and the busy indication. The arbiter takes the slave view.
interface sram_access_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) ();
  logic              i_wr_req;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_ack;
  logic              i_rd_req;
  logic [ADDR_W-1:0] i_rd_addr;
  logic              o_rd_valid;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_busy;

  modport slave (
    input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
    output o_wr_ack, o_rd_valid, o_rd_data, o_busy
  );

  modport master (
    output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
    input  o_wr_ack, o_rd_valid, o_rd_data, o_busy
  );
endinterface

// File: rtl/sram_access_arbiter_sel.sv
// Grant selection, combinational while en is high. Fixed write priority by
// default; SRAM_ARB_RR_EN enables a 1-bit round-robin pointer on ties.
module sram_arb_sel (
`ifdef SRAM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic en,
  input  logic req_wr,
  input  logic req_rd,
  output logic gnt_wr,
  output logic gnt_rd
);

`ifdef SRAM_ARB_RR_EN
  logic prio_rd;

  always_comb begin
    gnt_wr = en && req_wr && (!req_rd || !prio_rd);
    gnt_rd = en && req_rd && (!req_wr || prio_rd);
  end

  // Pointer moves on every grant, not only on contended ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_rd <= 1'b0;
    end else if (gnt_wr) begin
      prio_rd <= 1'b1;
    end else if (gnt_rd) begin
      prio_rd <= 1'b0;
    end
  end
`else
  always_comb begin
    gnt_wr = en && req_wr;
    gnt_rd = en && req_rd && !req_wr;
  end
`endif

endmodule

// File: rtl/sram_access_arbiter.sv
// Single-port SRAM controller sharing the bus between recorder writes and DSP reads.
// Write ack WAIT_CYC+2 / read valid WAIT_CYC+1 cycles after the IDLE grant; requests wait outside IDLE. Optional SRAM_ARB_RR_EN.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  sram_access_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              gnt_wr, gnt_rd;
  logic              dq_oe;
  strobe_t           stb;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  sram_arb_sel u_sel (
`ifdef SRAM_ARB_RR_EN
    .clk    (i_clk),
    .rst    (i_rst),
`endif
    .en     (state == ST_IDLE),
    .req_wr (bus.i_wr_req),
    .req_rd (bus.i_rd_req),
    .gnt_wr (gnt_wr),
    .gnt_rd (gnt_rd)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (gnt_wr) begin
        addr_q  <= bus.i_wr_addr;
        wdata_q <= bus.i_wr_data;
      end else if (gnt_rd) begin
        addr_q <= bus.i_rd_addr;
      end
      if (state == ST_RD_ACCESS && cnt == 4'd0) begin
        rdata_q <= io_SRAM_DQ;
      end
    end
  end

  // Strobes decode straight from the state register so reset releases them at once.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stb       = STROBE_IDLE;
    dq_oe     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gnt_wr) begin
          state_nxt = ST_WR_SETUP;
        end else if (gnt_rd) begin
          state_nxt = ST_RD_ACCESS;
          cnt_nxt   = CNT_LOAD;
        end
      end
      ST_WR_SETUP: begin
        stb.ce_n  = 1'b0;
        stb.lb_n  = 1'b0;
        stb.ub_n  = 1'b0;
        dq_oe     = 1'b1;
        state_nxt = ST_WR_PULSE;
        cnt_nxt   = CNT_LOAD;
      end
      ST_WR_PULSE: begin
        stb.ce_n = 1'b0;
        stb.lb_n = 1'b0;
        stb.ub_n = 1'b0;
        stb.we_n = 1'b0;
        dq_oe    = 1'b1;
        if (cnt == 4'd0) begin
          state_nxt = ST_WR_HOLD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_WR_HOLD: begin
        stb.ce_n  = 1'b0;
        stb.lb_n  = 1'b0;
        stb.ub_n  = 1'b0;
        dq_oe     = 1'b1;
        state_nxt = ST_TURN;
      end
      ST_RD_ACCESS: begin
        stb.ce_n = 1'b0;
        stb.oe_n = 1'b0;
        stb.lb_n = 1'b0;
        stb.ub_n = 1'b0;
        if (cnt == 4'd0) begin
          state_nxt = ST_RD_DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_RD_DONE: state_nxt = ST_TURN;
      ST_TURN:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign io_SRAM_DQ  = dq_oe ? wdata_q : 'z;
  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_WE_N = stb.we_n;
  assign o_SRAM_CE_N = stb.ce_n;
  assign o_SRAM_OE_N = stb.oe_n;
  assign o_SRAM_LB_N = stb.lb_n;
  assign o_SRAM_UB_N = stb.ub_n;

  assign bus.o_wr_ack   = (state == ST_WR_HOLD);
  assign bus.o_rd_valid = (state == ST_RD_DONE);
  assign bus.o_rd_data  = rdata_q;
  assign bus.o_busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench: main arbiter at WAIT_CYC=2 against a small SRAM model, plus
// WAIT_CYC=1 and 15 instances for latency checks.
module tb_sram_access_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nchk  = 0;
  int npass = 0;

  sram_access_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();
  sram_access_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus1 ();
  sram_access_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus15 ();

  logic [19:0] addr, addr1, addr15;
  wire  [15:0] dq, dq1, dq15;
  logic we_n, ce_n, oe_n, lb_n, ub_n;
  logic we1, ce1, oe1, lb1, ub1;
  logic we15, ce15, oe15, lb15, ub15;

  sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(2)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus), .o_SRAM_ADDR(addr), .io_SRAM_DQ(dq),
    .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n),
    .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
  );

  sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1), .o_SRAM_ADDR(addr1), .io_SRAM_DQ(dq1),
    .o_SRAM_WE_N(we1), .o_SRAM_CE_N(ce1), .o_SRAM_OE_N(oe1),
    .o_SRAM_LB_N(lb1), .o_SRAM_UB_N(ub1)
  );

  sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(15)) dut15 (
    .i_clk(clk), .i_rst(rst), .bus(bus15), .o_SRAM_ADDR(addr15), .io_SRAM_DQ(dq15),
    .o_SRAM_WE_N(we15), .o_SRAM_CE_N(ce15), .o_SRAM_OE_N(oe15),
    .o_SRAM_LB_N(lb15), .o_SRAM_UB_N(ub15)
  );

  // SRAM model: 256 words, write captured while WE_N is low, read driven while OE_N is low.
  logic [15:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  always @(posedge clk) if (!we_n && !ce_n) mem[addr[7:0]] <= dq;
  assign dq = (!ce_n && !oe_n && we_n) ? mem[addr[7:0]] : 'z;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Measures cycles from an IDLE request to its ack/valid on the sweep instances.
  task automatic latency(input int d, input bit is_wr, output int n);
    logic resp;
    if (d == 0) begin
      if (is_wr) bus1.i_wr_req = 1'b1; else bus1.i_rd_req = 1'b1;
    end else begin
      if (is_wr) bus15.i_wr_req = 1'b1; else bus15.i_rd_req = 1'b1;
    end
    n = 0;
    resp = 1'b0;
    while (!resp && n < 40) begin
      tick();
      n++;
      if (d == 0) resp = is_wr ? bus1.o_wr_ack : bus1.o_rd_valid;
      else        resp = is_wr ? bus15.o_wr_ack : bus15.o_rd_valid;
    end
    bus1.i_wr_req  = 1'b0;
    bus1.i_rd_req  = 1'b0;
    bus15.i_wr_req = 1'b0;
    bus15.i_rd_req = 1'b0;
    repeat (3) tick();
  endtask

  bit q[$];
  int nack, nvld, n;

  initial begin
    bus.i_wr_req = 0; bus.i_rd_req = 0;
    bus.i_wr_addr = '0; bus.i_wr_data = '0; bus.i_rd_addr = '0;
    bus1.i_wr_req = 0; bus1.i_rd_req = 0;
    bus1.i_wr_addr = 20'h00005; bus1.i_wr_data = 16'h1111; bus1.i_rd_addr = 20'h00005;
    bus15.i_wr_req = 0; bus15.i_rd_req = 0;
    bus15.i_wr_addr = 20'h00006; bus15.i_wr_data = 16'h2222; bus15.i_rd_addr = 20'h00006;

    repeat (2) tick();
    check("rst_busy", bus.o_busy, 0);
    check("rst_strobes", {we_n, ce_n, oe_n, lb_n, ub_n}, 5'b11111);
    check("rst_addr", addr, 0);
    check("rst_rd_data", bus.o_rd_data, 0);
    check("rst_ack_vld", {bus.o_wr_ack, bus.o_rd_valid}, 2'b00);
    rst = 1'b0;
    tick();

    // Reset arriving in the middle of a write pulse
    bus.i_wr_req = 1; bus.i_wr_addr = 20'h00020; bus.i_wr_data = 16'h1234;
    tick();
    check("mid_setup_we", we_n, 1);
    check("mid_setup_ce", ce_n, 0);
    tick();
    check("mid_pulse_we", we_n, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_we", we_n, 1);
    check("mid_rst_ce", ce_n, 1);
    check("mid_rst_busy", bus.o_busy, 0);
    check("mid_rst_addr", addr, 0);
    bus.i_wr_req = 0;
    tick();
    check("mid_rst_ack", bus.o_wr_ack, 0);
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_ack", bus.o_wr_ack, 0);
    check("post_rst_busy", bus.o_busy, 0);

    // Single write of 0xBEEF to 0x00010
    bus.i_wr_req = 1; bus.i_wr_addr = 20'h00010; bus.i_wr_data = 16'hBEEF;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("wr_we_t%0d", k), we_n, (k == 2 || k == 3) ? 1'b0 : 1'b1);
      check($sformatf("wr_ack_t%0d", k), bus.o_wr_ack, k == 4);
      check($sformatf("wr_busy_t%0d", k), bus.o_busy, k < 6);
      if (k == 4) bus.i_wr_req = 0;
    end
    check("wr_mem", mem[8'h10], 16'hBEEF);
    check("wr_addr_hold", addr, 20'h00010);

    // Single read of 0x00010
    bus.i_rd_req = 1; bus.i_rd_addr = 20'h00010;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("rd_oe_t%0d", k), oe_n, (k == 1 || k == 2) ? 1'b0 : 1'b1);
      check($sformatf("rd_vld_t%0d", k), bus.o_rd_valid, k == 3);
      if (k == 3) begin
        check("rd_data", bus.o_rd_data, 16'hBEEF);
        bus.i_rd_req = 0;
      end
    end
    check("rd_data_hold", bus.o_rd_data, 16'hBEEF);

    // Simultaneous requests: write first, read on the next IDLE visit
    bus.i_wr_req = 1; bus.i_wr_addr = 20'h00030; bus.i_wr_data = 16'hA5A5;
    bus.i_rd_req = 1; bus.i_rd_addr = 20'h00010;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check($sformatf("both_ack_t%0d", k), bus.o_wr_ack, k == 4);
      check($sformatf("both_vld_t%0d", k), bus.o_rd_valid, k == 9);
      if (k == 4) bus.i_wr_req = 0;
      if (k == 9) begin
        check("both_rd_data", bus.o_rd_data, 16'hBEEF);
        bus.i_rd_req = 0;
      end
    end
    check("both_mem", mem[8'h30], 16'hA5A5);

    // Both requests held continuously
    bus.i_wr_req = 1; bus.i_wr_addr = 20'h00040; bus.i_wr_data = 16'h5555;
    bus.i_rd_req = 1; bus.i_rd_addr = 20'h00030;
    nack = 0; nvld = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.o_wr_ack) begin
        nack++;
        q.push_back(1'b1);
      end
      if (bus.o_rd_valid) begin
        nvld++;
        q.push_back(1'b0);
        check("hold_rd_data", bus.o_rd_data, 16'hA5A5);
      end
    end
`ifdef SRAM_ARB_RR_EN
    check("rr_acks", nack, 4);
    check("rr_valids", nvld, 3);
    foreach (q[i]) check($sformatf("rr_order_%0d", i), q[i], (i % 2) == 0);
`else
    check("starve_acks", nack, 7);
    check("starve_valids", nvld, 0);
`endif
    bus.i_wr_req = 0; bus.i_rd_req = 0;
    n = 0;
    while (bus.o_busy && n < 20) begin
      tick();
      n++;
    end
    check("hold_idle", bus.o_busy, 0);
    check("hold_mem", mem[8'h40], 16'h5555);

    // WAIT_CYC sweep
    latency(0, 1'b1, n); check("w1_wr_lat", n, 3);
    latency(0, 1'b0, n); check("w1_rd_lat", n, 2);
    latency(1, 1'b1, n); check("w15_wr_lat", n, 17);
    latency(1, 1'b0, n); check("w15_rd_lat", n, 16);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/sram_access_arbiter.md
# sram_access_arbiter

Single-port SRAM access controller that shares the external 16-bit SRAM between the audio recorder (write requester) and the DSP/playback path (read requester). It serialises requests, generates SRAM control strobes with configurable access width, and inserts a bus-turnaround cycle between accesses. It sits between the recorder/DSP blocks and the SRAM pins, replacing direct mode-based muxing of the SRAM bus.

## Interface
- ADDR_W, 20, SRAM word address width
- DATA_W, 16, SRAM data width
- WAIT_CYC, 2, strobe-active cycles per access (legal range 1..15)

- i_clk  input  1  system clock
- i_rst  input  1  reset; asynchronous, active-high
- i_wr_req  input  1  write request (level, held until o_wr_ack)
- i_wr_addr  input  ADDR_W  write address (stable while i_wr_req=1)
- i_wr_data  input  DATA_W  write data (stable while i_wr_req=1)
- o_wr_ack  output  1  one-cycle pulse: write committed
- i_rd_req  input  1  read request (level, held until o_rd_valid)
- i_rd_addr  input  ADDR_W  read address (stable while i_rd_req=1)
- o_rd_valid  output  1  one-cycle pulse: o_rd_data valid
- o_rd_data  output  DATA_W  read data, holds last value between reads
- o_busy  output  1  high whenever state is not IDLE
- o_SRAM_ADDR  output  ADDR_W  SRAM address
- io_SRAM_DQ  inout  DATA_W  SRAM data, driven only in write states
- o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N  output  1 each  SRAM strobes, active-low

## Operation
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS, RD_DONE, TURN.
- IDLE: sample requests; latch chosen address (and write data) into internal registers; go WR_SETUP or RD_ACCESS. No request → stay.
- WR_SETUP (1 cycle): CE_N/LB_N/UB_N=0, WE_N=1, DQ driven.
- WR_PULSE (WAIT_CYC cycles): WE_N=0, DQ driven.
- WR_HOLD (1 cycle): WE_N=1, DQ still driven, o_wr_ack=1.
- RD_ACCESS (WAIT_CYC cycles): CE_N/OE_N/LB_N/UB_N=0, DQ Z; io_SRAM_DQ registered into o_rd_data at end of last cycle.
- RD_DONE (1 cycle): o_rd_valid=1, strobes deasserted.
- TURN (1 cycle): all strobes high, DQ Z, then IDLE; gives requesters one cycle to drop req.
- Strobes high and DQ Z in IDLE/TURN; o_SRAM_ADDR holds last latched address.
- Arbitration (default): fixed priority, write wins (recorder cannot stall).
- Requests are not sampled outside IDLE; a request rising mid-access waits.
- Req still high in IDLE after its ack/valid → treated as a new access (requester error, not detected).
- Internal wait counter 4 bits, reloads on each access entry; no wrap issue for WAIT_CYC≤15.

## Timing
- Reset (async, immediate, also mid-access): state IDLE, all strobes 1, DQ Z, o_wr_ack=0, o_rd_valid=0, o_rd_data=0, o_SRAM_ADDR=0, o_busy=0, RR pointer = write.
- Request sampled in IDLE cycle T: write ack at T+WAIT_CYC+2; read valid at T+WAIT_CYC+1.
- Back-to-back period: write WAIT_CYC+4 cycles, read WAIT_CYC+3 cycles.
- Simultaneous requests in IDLE: loser granted on next IDLE visit.
- Deassertion of req before ack: access already latched completes; ack/valid still pulses.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin; on simultaneous requests, the type not granted last wins; 1-bit pointer updates on every grant.
- Undefined: fixed write-priority as above; no pointer register.

## Structure
- Package sram_arb_pkg: state enum, default ADDR_W/DATA_W/WAIT_CYC constants, strobe-idle constant.
- One sub-module natural: sram_arb_sel (grant selection, fixed or RR per macro).

## Test plan
- Reset mid-WR_PULSE (WAIT_CYC=2): WE_N returns 1, DQ Z same cycle as i_rst rise; no ack issued.
- Write 0xBEEF to 0x00010, req sampled at T → WE_N=0 at T+2..T+3, o_wr_ack at T+4, idle at T+6; SRAM model holds 0xBEEF.
- Read 0x00010 at T → OE_N=0 at T+1..T+2, o_rd_valid at T+3 with o_rd_data=0xBEEF.
- Both requests at T, macro off → write ack T+4, read valid T+9; repeat with write held continuously → read starved.
- Macro on, both held continuously → grants alternate W,R,W,R; first grant write after reset.
- WAIT_CYC=1 and 15 parameter sweep: ack/valid latencies 3/2 and 17/16 cycles.
